// File: rtl/ara_rst_sequencer.sv
// rtl/ara_rst_sequencer.sv - parametrised PLL-lock qualified, ordered multi-domain reset sequencer
module ara_rst_sequencer #(
    parameter int unsigned NrDomains        = 3,
    parameter int unsigned SyncStages       = 2,
    parameter int unsigned LockStableCycles = 16,
    parameter int unsigned StepDelay        = 8,
    parameter int unsigned MinAssertCycles  = 4,
    parameter logic [NrDomains-1:0] NdmMask = NrDomains'(3'b110)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 pll_locked_i,
    input  logic                 ndmreset_i,
    input  logic                 sw_rst_req_i,
    output logic [NrDomains-1:0] domain_rst_no,
    output logic                 all_released_o,
    output logic [2:0]           state_o,
    output logic [7:0]           lock_lost_cnt_o
);

    localparam int unsigned LockW = (LockStableCycles > 1) ? $clog2(LockStableCycles) : 1;
    localparam int unsigned StepW = (StepDelay > 1) ? $clog2(StepDelay) : 1;
    localparam int unsigned HoldW = (MinAssertCycles > 1) ? $clog2(MinAssertCycles) : 1;
    localparam int unsigned IdxW  = (NrDomains > 1) ? $clog2(NrDomains) : 1;

    localparam logic [LockW-1:0] LockLast = LockW'(LockStableCycles - 1);
    localparam logic [StepW-1:0] StepLast = StepW'(StepDelay - 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(MinAssertCycles - 1);
    localparam logic [IdxW-1:0]  IdxLast  = IdxW'(NrDomains - 1);

    if (NrDomains < 1 || NrDomains > 8) begin : g_bad_nr_domains
        $error("NrDomains must be in 1..8");
    end
    if (SyncStages < 2) begin : g_bad_sync_stages
        $error("SyncStages must be >= 2");
    end
    if (LockStableCycles < 1) begin : g_bad_lock_stable
        $error("LockStableCycles must be >= 1");
    end
    if (StepDelay < 1) begin : g_bad_step_delay
        $error("StepDelay must be >= 1");
    end
    if (MinAssertCycles < 1) begin : g_bad_min_assert
        $error("MinAssertCycles must be >= 1");
    end

    typedef enum logic [2:0] {
        RESET_HOLD = 3'd0,
        WAIT_LOCK  = 3'd1,
        RELEASE    = 3'd2,
        RUN        = 3'd3,
        NDM_HOLD   = 3'd4
    } state_e;

    state_e                 state_q;
    logic [SyncStages-1:0]  sync_q;
    logic                   lock_s;
    logic [LockW-1:0]       lock_cnt_q;
    logic [StepW-1:0]       step_cnt_q;
    logic [HoldW-1:0]       hold_cnt_q;
    logic [IdxW-1:0]        idx_q;
    logic [NrDomains-1:0]   dom_q;
    logic                   all_rel_q;
    logic [7:0]             lost_cnt_q;

    // pll_locked_i is asynchronous; only the last stage is ever looked at
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SyncStages-2:0], pll_locked_i};
        end
    end

    assign lock_s = sync_q[SyncStages-1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= RESET_HOLD;
            lock_cnt_q <= '0;
            step_cnt_q <= '0;
            hold_cnt_q <= '0;
            idx_q      <= '0;
            dom_q      <= '0;
            all_rel_q  <= 1'b0;
            lost_cnt_q <= '0;
        end else begin
            case (state_q)
                RESET_HOLD: begin
                    dom_q      <= '0;
                    all_rel_q  <= 1'b0;
                    lock_cnt_q <= '0;
                    state_q    <= WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    dom_q     <= '0;
                    all_rel_q <= 1'b0;
                    if (sw_rst_req_i || !lock_s) begin
                        lock_cnt_q <= '0;
                    end else if (lock_cnt_q == LockLast) begin
                        state_q    <= RELEASE;
                        idx_q      <= '0;
                        step_cnt_q <= '0;
                    end else begin
                        lock_cnt_q <= lock_cnt_q + LockW'(1);
                    end
                end
                RELEASE, RUN, NDM_HOLD: begin
                    if (!lock_s) begin
                        state_q    <= WAIT_LOCK;
                        dom_q      <= '0;
                        all_rel_q  <= 1'b0;
                        lock_cnt_q <= '0;
                        if (lost_cnt_q != 8'hFF) begin
                            lost_cnt_q <= lost_cnt_q + 8'd1;
                        end
                    end else if (sw_rst_req_i) begin
                        state_q    <= WAIT_LOCK;
                        dom_q      <= '0;
                        all_rel_q  <= 1'b0;
                        lock_cnt_q <= '0;
                    end else if (state_q == NDM_HOLD) begin
                        if (!ndmreset_i && hold_cnt_q >= HoldLast) begin
                            state_q    <= RELEASE;
                            idx_q      <= '0;
                            step_cnt_q <= '0;
                        end else if (hold_cnt_q != HoldLast) begin
                            hold_cnt_q <= hold_cnt_q + HoldW'(1);
                        end
                    end else if (ndmreset_i) begin
                        // unmasked domains keep whatever they had, so a released fabric stays up
                        state_q    <= NDM_HOLD;
                        dom_q      <= dom_q & ~NdmMask;
                        all_rel_q  <= 1'b0;
                        hold_cnt_q <= '0;
                    end else if (state_q == RELEASE) begin
                        // every index costs a full step, even when that domain is already high
                        if (step_cnt_q == StepLast) begin
                            step_cnt_q   <= '0;
                            dom_q[idx_q] <= 1'b1;
                            if (idx_q == IdxLast) begin
                                state_q   <= RUN;
                                all_rel_q <= 1'b1;
                            end else begin
                                idx_q <= idx_q + IdxW'(1);
                            end
                        end else begin
                            step_cnt_q <= step_cnt_q + StepW'(1);
                        end
                    end
                end
                default: begin
                    state_q   <= RESET_HOLD;
                    dom_q     <= '0;
                    all_rel_q <= 1'b0;
                end
            endcase
        end
    end

    assign domain_rst_no   = dom_q;
    assign all_released_o  = all_rel_q;
    assign state_o         = state_q;
    assign lock_lost_cnt_o = lost_cnt_q;

endmodule
